// File: rtl/gost_pkg.sv
// rtl/gost_pkg.sv - shared constants, state type and counter arithmetic for the GOST gamma sequencer
//
// GOST_C1 / GOST_C2 : counter step constants for N4 / N3
// gamma_state_t     : sequencer states
// add_mod_2_32m1    : 32-bit addition modulo 2^32-1 (end-around carry)

package gost_pkg;

  localparam logic [31:0] GOST_C1 = 32'h01010104;
  localparam logic [31:0] GOST_C2 = 32'h01010101;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_S,
    STEP,
    WAIT_G,
    OUT
  } gamma_state_t;

  // The carry out of bit 31 is folded back into bit 0, which is what
  // reduces the sum modulo 2^32-1 rather than 2^32.
  function automatic logic [31:0] add_mod_2_32m1(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[31:0] + {31'd0, s[32]};
  endfunction

endpackage

// File: rtl/gost_28147_89.sv
// rtl/gost_28147_89.sv - iterative GOST 28147-89 block cipher core, one round per clock
//
// clk, rst   : clock, synchronous active-high reset
// kload, key : load the 256-bit key (key word i = key[32*i +: 32])
// mode       : 0 encrypt, 1 decrypt (sampled with load)
// select     : S-box set, 0 test set, 1 CryptoPro-A (sampled with load)
// load, pdata: start a block, pdata[31:0]=N1, pdata[63:32]=N2
// done, cdata: one-cycle completion pulse, 32 clocks after load; cdata held until next load

module gost_28147_89 (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         select,
  input  logic         kload,
  input  logic [255:0] key,
  input  logic         load,
  input  logic [63:0]  pdata,
  output logic         done,
  output logic [63:0]  cdata
);

  logic [255:0] key_r;
  logic [31:0]  n1, n2;
  logic [4:0]   rnd;
  logic         run, mode_r, sel_r;
  logic [2:0]   kidx;
  logic [31:0]  kw, sum, sub, f;

  // Each 64-bit row holds one S-box, entry x in nibble x.
  function automatic logic [3:0] sbox(input logic s, input logic [2:0] b, input logic [3:0] x);
    logic [63:0] row;
    row = '0;
    if (!s) begin
      case (b)
        3'd0: row = 64'h35F7C1B6E08D29A4;
        3'd1: row = 64'h95701832AFD6C4BE;
        3'd2: row = 64'hB9067CFE243AD185;
        3'd3: row = 64'h352BC64EF9801AD7;
        3'd4: row = 64'h2B30E9A48DF517C6;
        3'd5: row = 64'hEFC95863D1270AB4;
        3'd6: row = 64'hC2867EA095F314BD;
        default: row = 64'hC8B6E3294A750DF1;
      endcase
    end else begin
      case (b)
        3'd0: row = 64'h5D0CFE4A71B82369;
        3'd1: row = 64'h1D4BC6250FA89E73;
        3'd2: row = 64'h9170A5FC8D3B264E;
        3'd3: row = 64'h658F4B20931DCA7E;
        3'd4: row = 64'h6A7C324E0FD8915B;
        3'd5: row = 64'h6EF84957B021CDA3;
        3'd6: row = 64'hEB3F54C806A792D1;
        default: row = 64'h4D7193268EC05FAB;
      endcase
    end
    return row[{x, 2'b00} +: 4];
  endfunction

  // Encryption walks K0..K7 three times then K7..K0; decryption walks
  // K0..K7 once then K7..K0 three times.
  always_comb begin
    if (mode_r ? (rnd < 5'd8) : (rnd < 5'd24)) kidx = rnd[2:0];
    else                                       kidx = ~rnd[2:0];
    kw  = key_r[{kidx, 5'd0} +: 32];
    sum = n1 + kw;
    sub = '0;
    for (int i = 0; i < 8; i++) begin
      sub[4*i +: 4] = sbox(sel_r, 3'(i), sum[4*i +: 4]);
    end
    f = {sub[20:0], sub[31:21]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_r  <= '0;
      n1     <= '0;
      n2     <= '0;
      rnd    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
      mode_r <= 1'b0;
      sel_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kload) key_r <= key;
      if (load) begin
        n1     <= pdata[31:0];
        n2     <= pdata[63:32];
        rnd    <= '0;
        run    <= 1'b1;
        mode_r <= mode;
        sel_r  <= select;
      end else if (run) begin
        n1  <= n2 ^ f;
        n2  <= n1;
        rnd <= rnd + 5'd1;
        if (rnd == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Every round swaps the halves; the last swap is undone simply by the
  // order in which the halves are presented.
  assign cdata = {n1, n2};

endmodule

// File: rtl/gost_gamma_ctrl.sv
// rtl/gost_gamma_ctrl.sv - GOST 28147-89 gamma (counter) mode sequencer around one cipher core
//
// clk, rst                      : clock, synchronous active-low reset
// kload, key                    : key load strobe (IDLE only)
// start, iv                     : session start with sync vector (IDLE, key loaded)
// stop                          : end the session after the in-flight block
// in_valid/in_ready/in_data     : input block stream
// out_valid/out_ready/out_data  : output block stream, out_data = in_data ^ gamma
// busy                          : not IDLE
// ctr                           : counter {N4,N3} (feedback register in CFB)
// fb, dec                       : only with GOST_GAMMA_CFB_EN; CFB select and direction, sampled on start

module gost_gamma_ctrl
  import gost_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kload,
  input  logic [255:0] key,
  input  logic         start,
  input  logic [63:0]  iv,
  input  logic         stop,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy,
  output logic [63:0]  ctr
`ifdef GOST_GAMMA_CFB_EN
  ,
  input  logic         fb,
  input  logic         dec
`endif
);

  gamma_state_t state, state_nx;
  logic         key_ok, stop_seen, go_q;
  logic [31:0]  n3, n4;
  logic [63:0]  blk;
  logic         c_load, c_kload, c_done;
  logic [63:0]  c_data;
  logic         cfb, cfb_dec;

`ifdef GOST_GAMMA_CFB_EN
  logic fb_r, dec_r;
  assign cfb     = fb_r;
  assign cfb_dec = dec_r;
`else
  assign cfb     = 1'b0;
  assign cfb_dec = 1'b0;
`endif

  gost_28147_89 u_cipher (
    .clk   (clk),
    .rst   (~rst),
    .mode  (1'b0),
    .select(1'b0),
    .kload (c_kload),
    .key   (key),
    .load  (c_load),
    .pdata ({n4, n3}),
    .done  (c_done),
    .cdata (c_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    c_load    = go_q;    // block load follows input acceptance by one cycle
    c_kload   = 1'b0;
    case (state)
      IDLE: begin
        if (kload)                 c_kload  = 1'b1;
        else if (start && key_ok)  state_nx = SYNC;
      end
      SYNC: begin
        c_load   = 1'b1;
        state_nx = WAIT_S;
      end
      WAIT_S: if (c_done) state_nx = STEP;
      STEP: begin
        in_ready = 1'b1;
        if (in_valid)  state_nx = WAIT_G;
        else if (stop) state_nx = IDLE;
      end
      WAIT_G: if (c_done) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (stop || stop_seen) ? IDLE : STEP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_ok    <= 1'b0;
      stop_seen <= 1'b0;
      go_q      <= 1'b0;
      n3        <= '0;
      n4        <= '0;
      blk       <= '0;
      out_data  <= '0;
`ifdef GOST_GAMMA_CFB_EN
      fb_r      <= 1'b0;
      dec_r     <= 1'b0;
`endif
    end else begin
      go_q <= 1'b0;
      case (state)
        IDLE: begin
          stop_seen <= 1'b0;
          if (kload) begin
            key_ok <= 1'b1;
          end else if (start && key_ok) begin
            n3 <= iv[31:0];
            n4 <= iv[63:32];
`ifdef GOST_GAMMA_CFB_EN
            fb_r  <= fb;
            dec_r <= dec;
`endif
          end
        end
        // In CFB the first block is enciphered from the IV itself, so the
        // seed encryption result is not kept.
        WAIT_S: if (c_done && !cfb) {n4, n3} <= c_data;
        STEP: begin
          if (in_valid) begin
            blk       <= in_data;
            stop_seen <= stop;
            go_q      <= 1'b1;
            if (!cfb) begin
              n3 <= n3 + GOST_C2;
              n4 <= add_mod_2_32m1(n4, GOST_C1);
            end
          end
        end
        WAIT_G: begin
          if (stop) stop_seen <= 1'b1;
          if (c_done) begin
            out_data <= blk ^ c_data;
            if (cfb) {n4, n3} <= cfb_dec ? blk : (blk ^ c_data);
          end
        end
        OUT: if (out_ready) stop_seen <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ctr  = {n4, n3};

endmodule

// File: doc/gost_gamma_ctrl.md
# gost_gamma_ctrl

Stream-cipher sequencer for the `gost_28147_89` core, implementing GOST 28147-89 gamma (counter) mode. It owns one core instance and loads the key into it. It encrypts the sync vector (IV) once to seed the counter, then for each 64-bit input block steps the counter, runs the core, and XORs the resulting gamma onto the block. Encryption and decryption are the same operation. The block sits between a valid/ready data stream and the core's load/done handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous reset, active-low. Drives the core reset as `~rst`.
- `kload`  in  1  one-cycle strobe; samples `key`. Honoured only in IDLE.
- `key`  in  256  cipher key, same word/byte order as the core.
- `start`  in  1  one-cycle strobe; samples `iv` and begins a session. Honoured only in IDLE with a key loaded.
- `iv`  in  64  sync vector S; `iv[31:0]`=N1, `iv[63:32]`=N2.
- `stop`  in  1  ends the session. Takes effect in STEP or WAIT_G, or in OUT once the pending output is accepted.
- `in_valid` / `in_ready`  in/out  1  input block handshake.
- `in_data`  in  64  plain or cipher block.
- `out_valid` / `out_ready`  out/in  1  output block handshake.
- `out_data`  out  64  `in_data ^ gamma`.
- `busy`  out  1  high in every state except IDLE.
- `ctr`  out  64  current counter `{N4,N3}`, for debug and verification.
- `fb`  in  1  present only with `GOST_GAMMA_CFB_EN`; selects CFB for the session. Sampled on `start`.

## Operation
- Core is instantiated with `mode=0` (encrypt) permanently. `select` is tied to 0.
- **IDLE.** `kload` forwards a one-cycle `kload` to the core and sets `key_ok`. `start` with `key_ok` latches `iv` into `{N4,N3}` → SYNC.
- **SYNC.** Pulses core `load` with `pdata={N4,N3}` → WAIT_S.
- **WAIT_S.** On core `done`: `{N4,N3} <= cdata` → STEP.
- **STEP.** `in_ready=1`. On `in_valid`:
  - latch `in_data`;
  - N3 ← N3 + 0x01010101 mod 2^32;
  - N4 ← N4 + 0x01010104 mod (2^32−1), as a 33-bit sum with the carry added back into bit 0 (end-around carry);
  - pulse core `load` with the updated counter → WAIT_G.
- **WAIT_G.** On `done`: `out_data <= latched ^ cdata` → OUT.
- **OUT.** `out_valid=1`, data held stable. On `out_ready` → STEP, or → IDLE if `stop` is high or was seen earlier in this block.
- `stop` in STEP or WAIT_G returns to IDLE once the in-flight block completes. A block in WAIT_G finishes through OUT; no output is dropped.
- The key persists across sessions. `kload` outside IDLE is ignored.

## Timing
- Reset values:
  - `in_ready=0`, `out_valid=0`, `out_data=0`, `busy=0`, `ctr=0`;
  - state IDLE, `key_ok=0`;
  - core reset in the same cycle.
- Reset applied in any state aborts immediately. No output is produced for the in-flight block.
- Core `load` is launched the cycle after entering SYNC, and the cycle after input acceptance in STEP.
- Per-block latency, from input accept to `out_valid`: core latency + 2 clk.
- `out_valid` rises the cycle after `done`. It is never asserted together with `in_ready`, so throughput is one block per core run.
- `in_valid` held with `in_ready=0` is not consumed. `out_ready` low holds OUT indefinitely.
- `start` while busy is ignored. `kload` and `start` in the same IDLE cycle: the key is loaded and `start` is ignored.

## Configuration
- Macro: `GOST_GAMMA_CFB_EN`.
  - **Defined:** the `fb` port exists. When `fb=1` (CFB), the counter step is skipped. The core input for the next block is the previous *cipher* block: `out_data` when encrypting, `in_data` when decrypting. For the first block it is the IV. The direction comes from an extra `dec` input, sampled with `fb`. In CFB `ctr` shows the feedback register.
  - **Undefined:** `fb` and `dec` ports are absent. Only gamma (counter) mode is supported.

## Structure
- Package `gost_pkg`:
  - constants `GOST_C1=32'h01010104` and `GOST_C2=32'h01010101`;
  - state enum `gamma_state_t` (IDLE, SYNC, WAIT_S, STEP, WAIT_G, OUT);
  - function `add_mod_2_32m1`.
- One sub-module: `gost_28147_89`, instantiated as `u_cipher`.

## Test plan
- Counter arithmetic:
  - force N4=0xFFFFFFFF and N3=0xFFFFFFFF before STEP → `ctr` = {0x01010104, 0x01010100};
  - N4=0xFEFEFEFB → N4 = 0xFFFFFFFF, with no end-around increment.
- Round trip: key `swapkey(BE5EC200…997C0672)`, iv=0x0123456789ABCDEF, three blocks {0, 0xFFFFFFFFFFFFFFFF, 0x0DF82802B741A292}. Re-run a new session with the same key and iv, feeding the outputs → original three blocks returned.
- Gamma equals core output: plaintext 0 → `out_data` equals an independent core run on the stepped counter.
- Backpressure: `out_ready` low for 10 cycles → `out_data` stable, `in_ready=0` throughout, no core `load`.
- `stop` asserted in WAIT_G → that block's output is delivered, then IDLE. Next `start` without `kload` works with the stored key.
- Reset in WAIT_G → the next cycle has all outputs at reset values and `key_ok=0`. `start` before `kload` is ignored.
